// File: rtl/fwd_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit_pkg
//   Shared encodings for the EX-stage forwarding / load-use hazard unit.
//   - fwd_sel_e : operand mux select (register file, EX/MEM, MEM/WB)
//   - state_e   : stall state machine states
//   - REM_W     : width of the stall-remaining down-counter
// ---------------------------------------------------------------------------
package fwd_hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b10,
        FWD_MEMWB = 2'b01
    } fwd_sel_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    // Pipeline write-enable / bubble controls driven as one group.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_bubble;
    } stall_ctl_t;

    localparam int REM_W = 4;

endpackage

// File: rtl/fwd_hazard_unit_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk   - rising-edge clock
//     rst   - synchronous reset, active high
//     clr   - synchronous clear (wins over inc)
//     inc   - amount to add this cycle (INC_W bits, INC_W <= WIDTH)
//     cnt   - current count, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum;

    // One extra bit catches overflow, so +2 at all-ones-minus-1 saturates too.
    always_comb begin
        sum   = {1'b0, cnt_q} + {{(WIDTH+1-INC_W){1'b0}}, inc};
        cnt_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || clr) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//   EX-stage operand forwarding plus load-use hazard stall control.
//   Ports:
//     clk, reset_n              - clock; reset_n is active HIGH, synchronous
//     ex_rs/ex_rt(+_used)       - EX instruction source registers
//     ex_mem_*/mem_wb_*         - downstream writers (regwrite, rd)
//     id_rs/id_rt(+_used)       - ID instruction source registers
//     id_ex_memread, id_ex_rd   - EX instruction is a load, and its dest
//     flush                     - control-flow flush, beats any stall
//     cnt_clr                   - clear both event counters
//     forward_a/forward_b       - operand mux selects
//     pc_write, ifid_write      - front-end write enables
//     idex_bubble               - inject NOP into ID/EX
//     stall_active              - FSM sits in STALL
//     fwd_count, stall_count    - saturating event counters
// ---------------------------------------------------------------------------
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W         = 2,
    parameter int LOAD_STALL_CYCLES  = 1,
    parameter int CNT_W              = 16,
    parameter int ZERO_REG_HARDWIRED = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_rs_used,
    input  logic                  ex_rt_used,
    input  logic                  ex_mem_regwrite,
    input  logic                  mem_wb_regwrite,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  id_ex_memread,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  flush,
    input  logic                  cnt_clr,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_bubble,
    output logic                  stall_active,
    output logic [CNT_W-1:0]      fwd_count,
    output logic [CNT_W-1:0]      stall_count
);

    localparam bit ZR = (ZERO_REG_HARDWIRED != 0);

    // Port is named reset_n but asserts high.
    logic rst;
    assign rst = reset_n;

    // ------------------------------------------------------------------
    // Forwarding: operand 0 = rs (A), operand 1 = rt (B)
    // ------------------------------------------------------------------
    logic [1:0][REG_ADDR_W-1:0] ex_src;
    logic [1:0]                 ex_used;
    fwd_sel_e                   fwd_sel [2];
    logic [1:0]                 fwd_nz;

    assign ex_src  = {ex_rt, ex_rs};
    assign ex_used = {ex_rt_used, ex_rs_used};

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        logic exm_hit, wb_hit, zero_src;

        always_comb begin
            exm_hit  = ex_mem_regwrite && (ex_mem_rd == ex_src[g]) && ex_used[g];
            wb_hit   = mem_wb_regwrite && (mem_wb_rd == ex_src[g]) && ex_used[g];
            zero_src = ZR && (ex_src[g] == '0);
            // EX/MEM holds the younger result, so it outranks MEM/WB.
            if (rst || zero_src) fwd_sel[g] = FWD_RF;
            else if (exm_hit)    fwd_sel[g] = FWD_EXMEM;
            else if (wb_hit)     fwd_sel[g] = FWD_MEMWB;
            else                 fwd_sel[g] = FWD_RF;
        end

        assign fwd_nz[g] = (fwd_sel[g] != FWD_RF);
    end

    assign forward_a = fwd_sel[0];
    assign forward_b = fwd_sel[1];

    // ------------------------------------------------------------------
    // Load-use hazard detect
    // ------------------------------------------------------------------
    logic hz, zero_ld;

    always_comb begin
        zero_ld = ZR && (id_ex_rd == '0);
        hz      = id_ex_memread && !zero_ld &&
                  ((id_rs_used && (id_ex_rd == id_rs)) ||
                   (id_rt_used && (id_ex_rd == id_rt)));
    end

    // ------------------------------------------------------------------
    // Stall FSM: the IDLE cycle that detects the hazard is the first
    // bubble; STALL covers the remaining LOAD_STALL_CYCLES-1 bubbles.
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             stall;
    stall_ctl_t       ctl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (flush) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hz && (LOAD_STALL_CYCLES > 1)) begin
                        state_d = ST_STALL;
                        rem_d   = REM_W'(LOAD_STALL_CYCLES - 1);
                    end
                end
                ST_STALL: begin
                    // <=1 also recovers from a never-expected rem_q of 0.
                    if (rem_q <= REM_W'(1)) begin
                        state_d = ST_IDLE;
                        rem_d   = '0;
                    end else begin
                        rem_d   = rem_q - REM_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall = 1'b0;
        if (!rst && !flush)
            stall = (state_q == ST_STALL) || hz;
        ctl.pc_write    = !stall;
        ctl.ifid_write  = !stall;
        ctl.idex_bubble = stall;
    end

    assign pc_write     = ctl.pc_write;
    assign ifid_write   = ctl.ifid_write;
    assign idex_bubble  = ctl.idex_bubble;
    assign stall_active = (state_q == ST_STALL);

    // ------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------
    logic [1:0] fwd_inc;
    assign fwd_inc = {1'b0, fwd_nz[0]} + {1'b0, fwd_nz[1]};

    sat_counter #(.WIDTH(CNT_W), .INC_W(2)) u_fwd_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (fwd_inc),
        .cnt (fwd_count)
    );

    sat_counter #(.WIDTH(CNT_W), .INC_W(1)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (stall),
        .cnt (stall_count)
    );

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    localparam int RW = 2;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [RW-1:0] ex_rs, ex_rt, ex_mem_rd, mem_wb_rd, id_rs, id_rt, id_ex_rd;
    logic          ex_rs_used, ex_rt_used, ex_mem_regwrite, mem_wb_regwrite;
    logic          id_rs_used, id_rt_used, id_ex_memread, flush, cnt_clr;

    logic [1:0]    fa [2];
    logic [1:0]    fb [2];
    logic          pcw [2];
    logic          ifw [2];
    logic          bub [2];
    logic          sact [2];
    logic [CW-1:0] fc [2];
    logic [CW-1:0] sc [2];

    int ncmp  = 0;
    int nfail = 0;

    // Model state: extra bubbles still owed after the detecting cycle, counters.
    int left_m [2];
    int fc_m   [2];
    int sc_m   [2];

    always #5 clk = ~clk;

    // u0: 3-cycle load stall, register 0 forwardable
    fwd_hazard_unit #(.REG_ADDR_W(RW), .LOAD_STALL_CYCLES(3), .CNT_W(CW), .ZERO_REG_HARDWIRED(0)) u0 (
        .clk(clk), .reset_n(reset_n),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rs_used(ex_rs_used), .ex_rt_used(ex_rt_used),
        .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite),
        .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .flush(flush), .cnt_clr(cnt_clr),
        .forward_a(fa[0]), .forward_b(fb[0]), .pc_write(pcw[0]), .ifid_write(ifw[0]),
        .idex_bubble(bub[0]), .stall_active(sact[0]), .fwd_count(fc[0]), .stall_count(sc[0])
    );

    // u1: single-cycle load stall, register 0 hardwired
    fwd_hazard_unit #(.REG_ADDR_W(RW), .LOAD_STALL_CYCLES(1), .CNT_W(CW), .ZERO_REG_HARDWIRED(1)) u1 (
        .clk(clk), .reset_n(reset_n),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rs_used(ex_rs_used), .ex_rt_used(ex_rt_used),
        .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite),
        .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .flush(flush), .cnt_clr(cnt_clr),
        .forward_a(fa[1]), .forward_b(fb[1]), .pc_write(pcw[1]), .ifid_write(ifw[1]),
        .idex_bubble(bub[1]), .stall_active(sact[1]), .fwd_count(fc[1]), .stall_count(sc[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference forward select: 2 = EX/MEM, 1 = MEM/WB, 0 = register file.
    function automatic int mfwd(input bit zr, input logic [RW-1:0] src, input logic used);
        if (reset_n || !used) return 0;
        if (zr && src == 0) return 0;
        if (ex_mem_regwrite && ex_mem_rd == src) return 2;
        if (mem_wb_regwrite && mem_wb_rd == src) return 1;
        return 0;
    endfunction

    function automatic bit mhz(input bit zr);
        if (!id_ex_memread) return 0;
        if (zr && id_ex_rd == 0) return 0;
        return (id_rs_used && id_ex_rd == id_rs) || (id_rt_used && id_ex_rd == id_rt);
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Inputs already set at negedge; check, then advance the model over one edge.
    task automatic cycle();
        int nl [2];
        int nf [2];
        int ns [2];
        #2;
        for (int i = 0; i < 2; i++) begin
            bit zr = (i == 1);
            int L  = (i == 0) ? 3 : 1;
            int efa = mfwd(zr, ex_rs, ex_rs_used);
            int efb = mfwd(zr, ex_rt, ex_rt_used);
            bit h   = mhz(zr);
            bit est = !reset_n && !flush && (left_m[i] > 0 || h);
            int n   = (efa != 0 ? 1 : 0) + (efb != 0 ? 1 : 0);
            chk($sformatf("u%0d.forward_a", i), 32'(fa[i]), 32'(efa == 2 ? 2'b10 : efa == 1 ? 2'b01 : 2'b00));
            chk($sformatf("u%0d.forward_b", i), 32'(fb[i]), 32'(efb == 2 ? 2'b10 : efb == 1 ? 2'b01 : 2'b00));
            chk($sformatf("u%0d.pc_write", i), 32'(pcw[i]), 32'(!est));
            chk($sformatf("u%0d.ifid_write", i), 32'(ifw[i]), 32'(!est));
            chk($sformatf("u%0d.idex_bubble", i), 32'(bub[i]), 32'(est));
            chk($sformatf("u%0d.stall_active", i), 32'(sact[i]), 32'(left_m[i] > 0));
            chk($sformatf("u%0d.fwd_count", i), 32'(fc[i]), 32'(fc_m[i]));
            chk($sformatf("u%0d.stall_count", i), 32'(sc[i]), 32'(sc_m[i]));
            if (reset_n) begin
                nl[i] = 0; nf[i] = 0; ns[i] = 0;
            end else begin
                nf[i] = cnt_clr ? 0 : sat(fc_m[i] + n);
                ns[i] = cnt_clr ? 0 : sat(sc_m[i] + (est ? 1 : 0));
                if (flush)            nl[i] = 0;
                else if (left_m[i] > 0) nl[i] = left_m[i] - 1;
                else if (h)           nl[i] = L - 1;
                else                  nl[i] = 0;
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            left_m[i] = nl[i]; fc_m[i] = nf[i]; sc_m[i] = ns[i];
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        reset_n = 0; flush = 0; cnt_clr = 0;
        ex_rs = 0; ex_rt = 0; ex_rs_used = 0; ex_rt_used = 0;
        ex_mem_regwrite = 0; mem_wb_regwrite = 0; ex_mem_rd = 0; mem_wb_rd = 0;
        id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_ex_memread = 0; id_ex_rd = 0;
    endtask

    task automatic dbl_fwd();
        ex_mem_rd = 1; mem_wb_rd = 2; ex_mem_regwrite = 1; mem_wb_regwrite = 1;
        ex_rs = 1; ex_rt = 2; ex_rs_used = 1; ex_rt_used = 1;
    endtask

    task automatic load_use();
        id_ex_memread = 1; id_ex_rd = 2; id_rt = 2; id_rt_used = 1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            left_m[i] = 0; fc_m[i] = 0; sc_m[i] = 0;
        end
        quiet();
        reset_n = 1;
        @(negedge clk);
        // Reset held with forwarding conditions present: outputs forced.
        dbl_fwd(); reset_n = 1;
        #1 chk("rst.forward_a", 32'(fa[0]), 32'h0);
        cycle();

        // Double forward
        quiet(); cnt_clr = 1; cycle();
        quiet(); dbl_fwd();
        #1 chk("dbl.forward_a", 32'(fa[0]), 32'h2);
        chk("dbl.forward_b", 32'(fb[0]), 32'h1);
        cycle();
        quiet();
        #1 chk("dbl.fwd_count", 32'(fc[0]), 32'h2);
        cycle();

        // Priority
        ex_mem_rd = 3; mem_wb_rd = 3; ex_rs = 3; ex_rs_used = 1;
        ex_mem_regwrite = 1; mem_wb_regwrite = 1;
        #1 chk("prio.exmem", 32'(fa[0]), 32'h2);
        cycle();
        ex_mem_regwrite = 0;
        #1 chk("prio.memwb", 32'(fa[0]), 32'h1);
        cycle();
        ex_rs_used = 0;
        #1 chk("prio.unused", 32'(fa[0]), 32'h0);
        cycle();

        // Load-use, 3 bubbles on u0
        quiet(); cnt_clr = 1; cycle();
        quiet(); load_use();
        #1 chk("lu.c1.bubble", 32'(bub[0]), 32'h1);
        cycle();
        quiet();
        #1 chk("lu.c2.active", 32'(sact[0]), 32'h1);
        chk("lu.c2.bubble", 32'(bub[0]), 32'h1);
        cycle();
        #1 chk("lu.c3.bubble", 32'(bub[0]), 32'h1);
        cycle();
        #1 chk("lu.after.bubble", 32'(bub[0]), 32'h0);
        chk("lu.stall_count", 32'(sc[0]), 32'h3);
        cycle();

        // Flush in stall cycle 2
        quiet(); cnt_clr = 1; cycle();
        quiet(); load_use(); cycle();
        quiet(); flush = 1;
        #1 chk("fl.pc_write", 32'(pcw[0]), 32'h1);
        cycle();
        quiet();
        #1 chk("fl.idle", 32'(sact[0]), 32'h0);
        chk("fl.stall_count", 32'(sc[0]), 32'h1);
        cycle();

        // Saturation
        quiet(); cnt_clr = 1; cycle();
        quiet(); dbl_fwd();
        for (int k = 0; k < 7; k++) cycle();
        #1 chk("sat.14", 32'(fc[0]), 32'd14);
        cycle();
        #1 chk("sat.15", 32'(fc[0]), 32'd15);
        cycle();
        #1 chk("sat.hold", 32'(fc[0]), 32'd15);
        cnt_clr = 1; cycle();
        cnt_clr = 0;
        #1 chk("sat.clr", 32'(fc[0]), 32'd0);
        cycle();

        // Reset mid-stall with forwards active
        quiet(); load_use(); cycle();
        quiet(); dbl_fwd(); reset_n = 1;
        #1 chk("rs.forward_a", 32'(fa[0]), 32'h0);
        chk("rs.bubble", 32'(bub[0]), 32'h0);
        cycle();
        quiet();
        #1 chk("rs.active", 32'(sact[0]), 32'h0);
        chk("rs.fwd_count", 32'(fc[0]), 32'h0);
        load_use();
        #1 chk("rs.hz_resume", 32'(bub[0]), 32'h1);
        cycle();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            reset_n         = ($urandom_range(49) == 0);
            flush           = ($urandom_range(7) == 0);
            cnt_clr         = ($urandom_range(19) == 0);
            ex_rs           = RW'($urandom);
            ex_rt           = RW'($urandom);
            ex_rs_used      = 1'($urandom);
            ex_rt_used      = 1'($urandom);
            ex_mem_regwrite = 1'($urandom);
            mem_wb_regwrite = 1'($urandom);
            ex_mem_rd       = RW'($urandom);
            mem_wb_rd       = RW'($urandom);
            id_rs           = RW'($urandom);
            id_rt           = RW'($urandom);
            id_rs_used      = 1'($urandom);
            id_rt_used      = 1'($urandom);
            id_ex_memread   = ($urandom_range(2) == 0);
            id_ex_rd        = RW'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
